// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker.
package gate_chk_pkg;

    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;

    localparam logic [NUM_VEC-1:0] TRUTH_AND = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FINISH
    } state_e;

endpackage

// File: rtl/gate_chk_hold_timer.sv
// Loadable down-counter; expired is high once HOLD_CYCLES cycles have
// elapsed since the load edge (including the first cycle after load).
module gate_chk_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Self-test sequencer for a 2-input gate: drives 00,01,10,11, samples s after
// a settle time and compares against TRUTH. Macro GATE_CHK_FAILCAP_EN enables
// first-failure capture (fail_valid/fail_vec); otherwise those ports read 0.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int                 HOLD_CYCLES = 4,
    parameter logic [NUM_VEC-1:0] TRUTH       = TRUTH_AND,
    parameter int                 ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec
);

    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;

    logic start_acc;
    logic last_vec;
    logic mismatch;
    logic timer_load;
    logic timer_expired;

    assign start_acc  = (state_q == IDLE) && start;
    assign last_vec   = (vec_q == LAST_VEC);
    assign mismatch   = (state_q == SAMPLE) && (s != TRUTH[vec_q]);
    assign timer_load = (state_d == DRIVE) && (state_q != DRIVE);

    gate_chk_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .expired(timer_expired)
    );

    // NOTE: reset is synchronous, so it is tested inside the clocked block;
    // all state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (timer_expired) state_d = SAMPLE;
            SAMPLE:  state_d = last_vec ? FINISH : DRIVE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a    = 1'b0;
        b    = 1'b0;
        busy = 1'b0;
        case (state_q)
            DRIVE, SAMPLE: begin
                {a, b} = vec_q;
                busy   = 1'b1;
            end
            FINISH:  busy = 1'b1;
            default: ;
        endcase
    end

    // The verdict must include a mismatch found on the final vector's edge.
    always_comb begin
        vec_d     = vec_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
        done_d    = (state_q == SAMPLE) && last_vec;
        if (start_acc) begin
            vec_d     = '0;
            err_cnt_d = '0;
            pass_d    = 1'b0;
        end else if (state_q == SAMPLE) begin
            if (mismatch && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!last_vec) begin
                vec_d = vec_q + 1'b1;
            end else begin
                pass_d = (err_cnt_d == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q     <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
            done_q    <= done_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign pass    = pass_q;
    assign done    = done_q;

`ifdef GATE_CHK_FAILCAP_EN
    logic             fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0] fail_vec_q, fail_vec_d;

    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        if (start_acc) begin
            fail_valid_d = 1'b0;
            fail_vec_d   = '0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
`else
    assign fail_valid = 1'b0;
    assign fail_vec   = '0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: three instances (AND, XOR truth, 1-bit
// saturating counter) run in lockstep against a table-driven gate model.
module tb_gate_response_checker;

`ifdef GATE_CHK_FAILCAP_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [3:0] gate_tt;

    logic       a0, b0, s0, busy0, done0, pass0, fv0;
    logic [3:0] err0;
    logic [1:0] fvec0;
    logic       ax, bx, sx, busyx, donex, passx, fvx;
    logic [3:0] errx;
    logic [1:0] fvecx;
    logic       as, bs, ss, busys, dones, passs, fvs;
    logic [0:0] errs;
    logic [1:0] fvecs;

    // Gate under test: combinational lookup of the bench-chosen truth table.
    assign s0 = gate_tt[{a0, b0}];
    assign sx = gate_tt[{ax, bx}];
    assign ss = gate_tt[{as, bs}];

    gate_response_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0), .s(s0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_valid(fv0), .fail_vec(fvec0)
    );

    gate_response_checker #(.TRUTH(4'b0110)) dut_x (
        .clk(clk), .rst_n(rst_n), .start(start), .a(ax), .b(bx), .s(sx),
        .busy(busyx), .done(donex), .pass(passx), .err_cnt(errx),
        .fail_valid(fvx), .fail_vec(fvecx)
    );

    gate_response_checker #(.ERR_W(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .a(as), .b(bs), .s(ss),
        .busy(busys), .done(dones), .pass(passs), .err_cnt(errs),
        .fail_valid(fvs), .fail_vec(fvecs)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        string      name;
        logic [3:0] tt;
        int         exp_err;
        bit         exp_pass;
        logic [1:0] exp_fvec;
    } vec_t;

    vec_t table_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle n is the interval after edge n-1; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: walk the four vectors, count disagreements, note the first.
    function automatic void model(input logic [3:0] truth, input logic [3:0] gate,
                                  input int max_err, output int err,
                                  output bit any, output logic [1:0] first);
        err   = 0;
        any   = 1'b0;
        first = 2'b00;
        for (int v = 0; v < 4; v++) begin
            if (gate[v] != truth[v]) begin
                if (!any) first = v[1:0];
                any = 1'b1;
                if (err < max_err) err++;
            end
        end
    endfunction

    task automatic run_check(input string name, input logic [3:0] tt, input int exp_err0,
                             input bit exp_pass0, input logic [1:0] exp_fvec0);
        int         dcyc[3];
        int         npulse[3];
        int         vec_bad;
        int         ex, es, d0;
        bit         anyx, anys, any0;
        logic [1:0] fx, fs, f0;
        logic [2:0] dn;
        model(4'b0110, tt, 15, ex, anyx, fx);
        model(4'b1000, tt, 1, es, anys, fs);
        model(4'b1000, tt, 15, d0, any0, f0);
        vec_bad = 0;
        for (int k = 0; k < 3; k++) begin
            dcyc[k]   = 0;
            npulse[k] = 0;
        end
        @(negedge clk);
        gate_tt = tt;
        start   = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cyc == 1) begin
                start = 1'b0;
                check({name, " busy@1"}, busy0, 1);
                check({name, " err cleared"}, err0, 0);
                check({name, " pass cleared"}, pass0, 0);
                check({name, " fv cleared"}, fv0, 0);
            end
            if (cyc <= 20 && {a0, b0} != 2'((cyc - 1) / 5)) vec_bad++;
            if (cyc == 21) check({name, " busy in FINISH"}, busy0, 1);
            if (cyc == 22) check({name, " busy idle"}, busy0, 0);
            dn = {dones, donex, done0};
            for (int k = 0; k < 3; k++) begin
                if (dn[k]) begin
                    npulse[k]++;
                    dcyc[k] = cyc;
                end
            end
        end
        check({name, " vector sequence"}, vec_bad, 0);
        check({name, " done cycle"}, dcyc[0], 21);
        check({name, " done pulses"}, npulse[0], 1);
        check({name, " err_cnt"}, err0, exp_err0);
        check({name, " pass"}, pass0, exp_pass0);
        check({name, " model agrees"}, d0, exp_err0);
        check({name, " fail_valid"}, fv0, CAP && (exp_err0 > 0));
        check({name, " fail_vec"}, fvec0, CAP ? exp_fvec0 : 2'b00);
        check({name, " xor done cycle"}, dcyc[1], 21);
        check({name, " xor err_cnt"}, errx, ex);
        check({name, " xor pass"}, passx, !anyx);
        check({name, " xor fail_valid"}, fvx, CAP && anyx);
        check({name, " xor fail_vec"}, fvecx, CAP ? fx : 2'b00);
        check({name, " sat done pulses"}, npulse[2], 1);
        check({name, " sat err_cnt"}, errs, es);
        check({name, " sat pass"}, passs, !anys);
    endtask

    initial begin
        int         e0;
        bit         any0;
        logic [1:0] f0;
        logic [3:0] rtt;
        int         pulses;

        table_q.push_back('{"and_ok",  4'b1000, 0, 1'b1, 2'b00});
        table_q.push_back('{"stuck0",  4'b0000, 1, 1'b0, 2'b11});
        table_q.push_back('{"stuck1",  4'b1111, 3, 1'b0, 2'b00});
        table_q.push_back('{"and_ok2", 4'b1000, 0, 1'b1, 2'b00});
        table_q.push_back('{"or_gate", 4'b1110, 2, 1'b0, 2'b01});

        rst_n   = 1'b0;
        start   = 1'b0;
        gate_tt = 4'b1000;
        repeat (3) step();
        check("reset busy", busy0, 0);
        check("reset done", done0, 0);
        check("reset pass", pass0, 0);
        check("reset err", err0, 0);
        check("reset ab", {a0, b0}, 0);
        check("reset fv", fv0, 0);
        check("reset fvec", fvec0, 0);

        // Reset and start together: reset must win.
        @(negedge clk);
        start = 1'b1;
        step();
        check("reset beats start", busy0, 0);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        check("idle after reset", busy0, 0);

        foreach (table_q[i]) begin
            run_check(table_q[i].name, table_q[i].tt, table_q[i].exp_err,
                      table_q[i].exp_pass, table_q[i].exp_fvec);
        end

        for (int r = 0; r < 8; r++) begin
            rtt = 4'($urandom_range(0, 15));
            model(4'b1000, rtt, 15, e0, any0, f0);
            run_check($sformatf("rand%0d", r), rtt, e0, !any0, f0);
        end

        // Start re-pulsed in cycle 7 is ignored.
        @(negedge clk);
        gate_tt = 4'b1000;
        start   = 1'b1;
        cyc     = 0;
        pulses  = 0;
        e0      = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            start = (cyc == 6);
            if (done0) begin
                pulses++;
                e0 = cyc;
            end
        end
        check("restart done cycle", e0, 21);
        check("restart done pulses", pulses, 1);
        check("restart pass", pass0, 1);

        // Reset in cycle 10 of a failing run.
        @(negedge clk);
        gate_tt = 4'b1111;
        start   = 1'b1;
        cyc     = 0;
        pulses  = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cyc == 1) start = 1'b0;
            if (cyc == 9) begin
                check("pre-reset err", err0, 1);
                check("pre-reset busy", busy0, 1);
                rst_n = 1'b0;
            end
            if (cyc == 10) begin
                rst_n = 1'b1;
                check("midreset busy", busy0, 0);
                check("midreset err", err0, 0);
                check("midreset ab", {a0, b0}, 0);
                check("midreset pass", pass0, 0);
                check("midreset fv", fv0, 0);
                check("midreset done", done0, 0);
            end
            if (done0) pulses++;
        end
        check("midreset no done", pulses, 0);
        run_check("after_reset", 4'b1000, 0, 1'b1, 2'b00);

        // Start held high: next run begins the cycle after returning to IDLE.
        @(negedge clk);
        gate_tt = 4'b1000;
        start   = 1'b1;
        cyc     = 0;
        e0      = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (done0 && e0 == 0) e0 = cyc;
            if (cyc == 22) check("held start idle gap", busy0, 0);
            if (cyc == 23) check("held start restart", busy0, 1);
        end
        check("held start done cycle", e0, 21);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done0) pulses++;
        end
        check("held start second run done", pulses, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
